// File: rtl/imem_fetch_arbiter.sv
// Instruction ROM arbiter: shares a synchronous ROM between the core fetch port (IF) and a
// debug/loader port (DBG). One transaction in flight, 1 read/cycle back-to-back, range and
// alignment faults, IF flush, and starvation-bounded fixed priority (IF high).
// Optional performance counters are built when IMEM_ARB_PERF_CNT_EN is defined.
`timescale 1ns/1ps

module imem_fetch_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_fault,
  input  logic        if_rsp_ready,
  input  logic        if_flush,
  input  logic        dbg_req_valid,
  input  logic [31:0] dbg_req_addr,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        dbg_rsp_fault,
  input  logic        dbg_rsp_ready,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
`ifdef IMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_reads,
  output logic [31:0] perf_dbg_reads,
  output logic [31:0] perf_conflicts
`endif
);

  localparam logic [31:0] MemBytes  = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic {OwnIf, OwnDbg} owner_e;

  logic       pend_q, pend_d;
  owner_e     owner_q, owner_d;
  logic       fault_q, fault_d;
  logic [3:0] starve_q, starve_d;

  logic        if_active, dbg_active, slot_free, dbg_sel;
  logic        if_acc, dbg_acc, accept, legal;
  logic [31:0] offset;

  // Slot status, arbitration, ROM request and response steering.
  always_comb begin
    if_active     = pend_q && (owner_q == OwnIf);
    dbg_active    = pend_q && (owner_q == OwnDbg);
    if_rsp_valid  = if_active && !if_flush;
    dbg_rsp_valid = dbg_active;
    // Gated by rst_n so nothing is granted or read while reset is held.
    slot_free     = rst_n && (!pend_q || (if_rsp_valid && if_rsp_ready) ||
                              (dbg_rsp_valid && dbg_rsp_ready) || (if_active && if_flush));
    // DBG wins when IF is idle or DBG has hit its starvation bound.
    dbg_sel       = dbg_req_valid && (!if_req_valid || (starve_q == StarveMax));
    if_req_ready  = slot_free && !dbg_sel;
    dbg_req_ready = slot_free && dbg_sel;
    if_acc        = if_req_valid && if_req_ready;
    dbg_acc       = dbg_req_valid && dbg_req_ready;
    accept        = if_acc || dbg_acc;
    mem_addr      = dbg_sel ? dbg_req_addr : if_req_addr;
    offset        = mem_addr - BASE_ADDR;
    legal         = (mem_addr[1:0] == 2'b00) && (offset < MemBytes);
    mem_rd        = accept && legal;
    if_rsp_fault  = if_rsp_valid && fault_q;
    dbg_rsp_fault = dbg_rsp_valid && fault_q;
    if_rsp_data   = (if_rsp_valid && !fault_q) ? mem_rdata : 32'h0;
    dbg_rsp_data  = (dbg_rsp_valid && !fault_q) ? mem_rdata : 32'h0;
  end

  // Next-state for the slot and the DBG starvation counter.
  always_comb begin
    pend_d   = pend_q;
    owner_d  = owner_q;
    fault_d  = fault_q;
    starve_d = starve_q;
    if (accept) begin
      pend_d  = 1'b1;
      owner_d = dbg_sel ? OwnDbg : OwnIf;
      fault_d = !legal;
    end else if (slot_free) begin
      pend_d  = 1'b0;
    end
    if (!dbg_req_valid || dbg_acc) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Slot and starvation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      owner_q  <= OwnIf;
      fault_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      fault_q  <= fault_d;
      starve_q <= starve_d;
    end
  end

`ifdef IMEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_dbg_q, perf_conf_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q   <= 32'd0;
      perf_dbg_q  <= 32'd0;
      perf_conf_q <= 32'd0;
    end else begin
      if (if_acc)                         perf_if_q   <= perf_if_q + 32'd1;
      if (dbg_acc)                        perf_dbg_q  <= perf_dbg_q + 32'd1;
      if (if_req_valid && dbg_req_valid)  perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_if_reads  = perf_if_q;
  assign perf_dbg_reads = perf_dbg_q;
  assign perf_conflicts = perf_conf_q;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a behavioural synchronous ROM.
`timescale 1ns/1ps

module tb_imem_fetch_arbiter;

  localparam logic [31:0] B = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_fault, if_rsp_ready, if_flush;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_fault, dbg_rsp_ready;
  logic [31:0] dbg_req_addr, dbg_rsp_data;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  imem_fetch_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_fault (if_rsp_fault),
    .if_rsp_ready (if_rsp_ready),
    .if_flush     (if_flush),
    .dbg_req_valid(dbg_req_valid),
    .dbg_req_addr (dbg_req_addr),
    .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_data (dbg_rsp_data),
    .dbg_rsp_fault(dbg_rsp_fault),
    .dbg_rsp_ready(dbg_rsp_ready),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // ROM word i holds A5A5_0000 + i.
  function automatic logic [31:0] w(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= w(int'(mem_addr[11:2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = B; if_rsp_ready = 1'b1; if_flush = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_addr = 32'h0; dbg_rsp_ready = 1'b1;
    #3;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_if_req_ready", 32'(if_req_ready), 32'd0);
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rst_if_rsp_fault", 32'(if_rsp_fault), 32'd0);
    if_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    rst_n = 1'b1;
    cyc();

    // IF streaming, three back-to-back reads
    if_req_valid = 1'b1; if_req_addr = B;
    smp();
    chk("stream_rd0", 32'(mem_rd), 32'd1);
    chk("stream_addr0", mem_addr, B);
    chk("stream_noval0", 32'(if_rsp_valid), 32'd0);
    cyc(); if_req_addr = B + 32'h4;
    smp();
    chk("stream_val1", 32'(if_rsp_valid), 32'd1);
    chk("stream_data0", if_rsp_data, w(0));
    chk("stream_rd1", 32'(mem_rd), 32'd1);
    cyc(); if_req_addr = B + 32'h8;
    smp();
    chk("stream_data1", if_rsp_data, w(1));
    chk("stream_rd2", 32'(mem_rd), 32'd1);
    cyc(); if_req_valid = 1'b0;
    smp();
    chk("stream_val3", 32'(if_rsp_valid), 32'd1);
    chk("stream_data2", if_rsp_data, w(2));
    chk("stream_rd_idle", 32'(mem_rd), 32'd0);
    cyc();
    smp();
    chk("stream_val_end", 32'(if_rsp_valid), 32'd0);

    // Backpressure: response held for 5 cycles with a new request waiting
    cyc(); if_req_valid = 1'b1; if_req_addr = B + 32'h10; if_rsp_ready = 1'b0;
    smp();
    chk("bp_rd", 32'(mem_rd), 32'd1);
    cyc(); if_req_addr = B + 32'h14;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_valid", 32'(if_rsp_valid), 32'd1);
      chk("bp_data", if_rsp_data, w(4));
      chk("bp_req_ready", 32'(if_req_ready), 32'd0);
      chk("bp_mem_rd", 32'(mem_rd), 32'd0);
      cyc();
    end
    if_req_valid = 1'b0; if_rsp_ready = 1'b1;
    smp();
    chk("bp_release_data", if_rsp_data, w(4));
    cyc();
    smp();
    chk("bp_end_valid", 32'(if_rsp_valid), 32'd0);

    // Faults: out of range, then misaligned
    cyc(); if_req_valid = 1'b1; if_req_addr = B + 32'h1000;
    smp();
    chk("flt_range_rd", 32'(mem_rd), 32'd0);
    chk("flt_range_ready", 32'(if_req_ready), 32'd1);
    cyc(); if_req_addr = B + 32'h2;
    smp();
    chk("flt_range_valid", 32'(if_rsp_valid), 32'd1);
    chk("flt_range_fault", 32'(if_rsp_fault), 32'd1);
    chk("flt_range_data", if_rsp_data, 32'h0);
    chk("flt_align_rd", 32'(mem_rd), 32'd0);
    cyc(); if_req_valid = 1'b0;
    smp();
    chk("flt_align_fault", 32'(if_rsp_fault), 32'd1);
    chk("flt_align_data", if_rsp_data, 32'h0);
    cyc();
    smp();
    chk("flt_end_valid", 32'(if_rsp_valid), 32'd0);
    chk("flt_end_fault", 32'(if_rsp_fault), 32'd0);

    // Starvation: DBG forced a grant in cycle 4
    cyc();
    dbg_req_valid = 1'b1; dbg_req_addr = B + 32'h100;
    for (int c = 0; c < 4; c++) begin
      if_req_valid = 1'b1; if_req_addr = B + 32'(4 * c);
      smp();
      chk("stv_if_ready", 32'(if_req_ready), 32'd1);
      chk("stv_dbg_ready", 32'(dbg_req_ready), 32'd0);
      cyc();
    end
    if_req_addr = B + 32'h20;
    smp();
    chk("stv_c4_dbg_ready", 32'(dbg_req_ready), 32'd1);
    chk("stv_c4_if_ready", 32'(if_req_ready), 32'd0);
    chk("stv_c4_addr", mem_addr, B + 32'h100);
    chk("stv_c4_if_data", if_rsp_data, w(3));
    cyc(); dbg_req_valid = 1'b0;
    smp();
    chk("stv_c5_dbg_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("stv_c5_dbg_data", dbg_rsp_data, w(64));
    chk("stv_c5_if_valid", 32'(if_rsp_valid), 32'd0);
    chk("stv_c5_if_ready", 32'(if_req_ready), 32'd1);
    cyc(); if_req_valid = 1'b0;
    smp();
    chk("stv_c6_if_data", if_rsp_data, w(8));
    chk("stv_c6_dbg_valid", 32'(dbg_rsp_valid), 32'd0);
    cyc();

    // Flush: word 8 dropped, redirect to word 16
    if_req_valid = 1'b1; if_req_addr = B + 32'h20;
    smp();
    chk("fl_rd", 32'(mem_rd), 32'd1);
    cyc(); if_flush = 1'b1; if_req_addr = B + 32'h40;
    smp();
    chk("fl_valid_drop", 32'(if_rsp_valid), 32'd0);
    chk("fl_ready", 32'(if_req_ready), 32'd1);
    chk("fl_addr", mem_addr, B + 32'h40);
    chk("fl_rd2", 32'(mem_rd), 32'd1);
    cyc(); if_flush = 1'b0; if_req_valid = 1'b0;
    smp();
    chk("fl_valid", 32'(if_rsp_valid), 32'd1);
    chk("fl_data", if_rsp_data, w(16));
    cyc();
    smp();
    chk("fl_end_valid", 32'(if_rsp_valid), 32'd0);

    // Flush does not touch a DBG-owned slot
    cyc(); dbg_req_valid = 1'b1; dbg_req_addr = B + 32'h8; dbg_rsp_ready = 1'b0;
    smp();
    chk("dfl_ready", 32'(dbg_req_ready), 32'd1);
    cyc(); dbg_req_valid = 1'b0; if_flush = 1'b1;
    smp();
    chk("dfl_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("dfl_data", dbg_rsp_data, w(2));
    chk("dfl_slot_busy", 32'(if_req_ready), 32'd0);
    cyc(); if_flush = 1'b0; dbg_rsp_ready = 1'b1;
    smp();
    chk("dfl_valid_after", 32'(dbg_rsp_valid), 32'd1);
    cyc();
    smp();
    chk("dfl_end_valid", 32'(dbg_rsp_valid), 32'd0);

    // Reset while a response is pending
    cyc(); if_req_valid = 1'b1; if_req_addr = B + 32'h30; if_rsp_ready = 1'b0;
    cyc(); if_req_valid = 1'b0;
    smp();
    chk("mr_valid_before", 32'(if_rsp_valid), 32'd1);
    chk("mr_data_before", if_rsp_data, w(12));
    #1 rst_n = 1'b0;
    #1;
    chk("mr_if_valid", 32'(if_rsp_valid), 32'd0);
    chk("mr_dbg_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("mr_mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    smp();
    rst_n = 1'b1;
    cyc(); if_req_valid = 1'b1; if_req_addr = B + 32'h34; if_rsp_ready = 1'b1;
    smp();
    chk("mr_post_rd", 32'(mem_rd), 32'd1);
    cyc(); if_req_valid = 1'b0;
    smp();
    chk("mr_post_valid", 32'(if_rsp_valid), 32'd1);
    chk("mr_post_data", if_rsp_data, w(13));
    chk("mr_post_fault", 32'(if_rsp_fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
